// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS control FSM with mem_ready wait states and a timeout watchdog.
// Define MULTICYCLE_JAL_EN to decode opcode 0x03 as JAL (PC+4 written to $31 in JUMP).
module multicycle_control #(
   parameter int ALUOP_WIDTH = 3,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [5:0]             op,
   input  logic                   zero,
   input  logic                   mem_ready,
   output logic                   pc_write,
   output logic                   ir_write,
   output logic                   reg_write,
   output logic                   mem_read,
   output logic                   mem_write,
   output logic                   iord,
   output logic                   alu_src_a,
   output logic [1:0]             alu_src_b,
   output logic [1:0]             reg_dst,
   output logic [1:0]             mem_to_reg,
   output logic [1:0]             pc_source,
   output logic [ALUOP_WIDTH-1:0] alu_op,
   output logic [3:0]             state,
   output logic                   illegal_op,
   output logic                   timeout
);
   typedef enum logic [3:0] {
      FETCH = 4'd0, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB,
      EXEC_I, I_WB, BRANCH, JUMP, ERROR
   } stateT;
   localparam int CW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT + 1) : 1;
   stateT cur, nextState, decodeNext;
   logic [CW-1:0] waitCnt;
   logic isWait, expire, isJal;
   logic [2:0] aluFn;
`ifdef MULTICYCLE_JAL_EN
   assign isJal = op == 6'h03;
`else
   assign isJal = 1'b0;
`endif
   assign isWait = cur == FETCH || cur == MEM_RD || cur == MEM_WR;
   assign expire = MEM_TIMEOUT != 0 && isWait && !mem_ready && waitCnt == CW'(MEM_TIMEOUT - 1);
   always_comb begin
      decodeNext = FETCH;
      case (op)
         6'h00: decodeNext = EXEC_R;
         6'h23, 6'h2b: decodeNext = MEM_ADDR;
         6'h08, 6'h0c, 6'h0d, 6'h0f: decodeNext = EXEC_I;
         6'h04, 6'h05: decodeNext = BRANCH;
         6'h02: decodeNext = JUMP;
`ifdef MULTICYCLE_JAL_EN
         6'h03: decodeNext = JUMP;
`endif
         default: decodeNext = FETCH;
      endcase
   end
   always_comb begin
      nextState = FETCH;
      case (cur)
         FETCH: nextState = mem_ready ? DECODE : FETCH;
         DECODE: nextState = decodeNext;
         MEM_ADDR: nextState = op == 6'h23 ? MEM_RD : MEM_WR;
         MEM_RD: nextState = mem_ready ? MEM_WB : MEM_RD;
         MEM_WR: nextState = mem_ready ? FETCH : MEM_WR;
         EXEC_R: nextState = R_WB;
         EXEC_I: nextState = I_WB;
         ERROR: nextState = ERROR;
         default: nextState = FETCH;
      endcase
      if (expire) nextState = ERROR;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         cur <= FETCH;
         waitCnt <= '0;
         illegal_op <= 1'b0;
         timeout <= 1'b0;
      end else begin
         cur <= nextState;
         waitCnt <= isWait && !mem_ready ? waitCnt + 1'b1 : '0;
         illegal_op <= illegal_op | (cur == DECODE && decodeNext == FETCH);
         timeout <= timeout | expire;
      end
   end
   always_comb begin
      pc_write = 1'b0;
      ir_write = 1'b0;
      reg_write = 1'b0;
      mem_read = 1'b0;
      mem_write = 1'b0;
      iord = 1'b0;
      alu_src_a = 1'b0;
      alu_src_b = 2'b00;
      reg_dst = 2'b00;
      mem_to_reg = 2'b00;
      pc_source = 2'b00;
      aluFn = 3'b000;
      case (cur)
         FETCH: begin
            mem_read = 1'b1;
            alu_src_b = 2'b01;
            aluFn = 3'b010;
            ir_write = mem_ready;
            pc_write = mem_ready;
         end
         DECODE: begin
            alu_src_b = 2'b11;
            aluFn = 3'b010;
         end
         MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            aluFn = 3'b010;
         end
         MEM_RD: begin
            iord = 1'b1;
            mem_read = 1'b1;
         end
         MEM_WB: begin
            reg_write = 1'b1;
            mem_to_reg = 2'b01;
         end
         MEM_WR: begin
            iord = 1'b1;
            mem_write = 1'b1;
         end
         EXEC_R: begin
            alu_src_a = 1'b1;
            aluFn = 3'b111;
         end
         R_WB: begin
            reg_write = 1'b1;
            reg_dst = 2'b01;
         end
         EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            aluFn = op == 6'h08 ? 3'b110 : op == 6'h0c ? 3'b011 : op == 6'h0d ? 3'b101 : 3'b001;
         end
         I_WB: reg_write = 1'b1;
         BRANCH: begin
            alu_src_a = 1'b1;
            aluFn = 3'b100;
            pc_source = 2'b01;
            pc_write = op == 6'h04 ? zero : !zero;
         end
         JUMP: begin
            pc_source = 2'b10;
            pc_write = 1'b1;
            reg_write = isJal;
            reg_dst = isJal ? 2'b10 : 2'b00;
            mem_to_reg = isJal ? 2'b10 : 2'b00;
         end
         default: aluFn = 3'b000;
      endcase
      // reset aborts any in-flight instruction without a stray strobe
      if (reset) {pc_write, ir_write, reg_write, mem_read, mem_write} = 5'b0;
   end
   assign alu_op = ALUOP_WIDTH'(aluFn);
   assign state = cur;
endmodule
